// File: rtl/lifo_arb_pkg.sv
// lifo_arb_pkg
// Shared definitions for the LIFO port arbiter: FSM state encoding, the
// requester-index width helper and the per-cycle LIFO opcode.
package lifo_arb_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } lifo_op_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: scans the eligible vector starting
// at rr_ptr, wrapping modulo N, and returns the first hit.
// Ports:
//   eligible  in  N     requesters allowed to win this cycle
//   rr_ptr    in  ID_W  first index to look at (always < N)
//   gnt       out N     one-hot grant, all zero when nothing is eligible
//   gnt_idx   out ID_W  index of the winner (0 when no grant)
//   gnt_valid out 1     a grant was issued
module rr_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lifo_port_arbiter.sv
// lifo_port_arbiter
// Shares one LIFO between N_REQ requesters, granting at most one push or pop
// per cycle in round-robin order, and returns popped words to the winner one
// cycle later. A flush pulse drains the LIFO without producing responses.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req_push, req_pop    per-requester level requests, held until granted
//   push_data            packed push words, requester i at [i*DATA_W +: DATA_W]
//   gnt                  one-hot combinational grant
//   rsp_valid/id/data    registered pop response (1-cycle pulse)
//   flush, busy          drain command / high while draining
//   flush_done           1-cycle pulse after the drain completes
//   lifo_write/read/
//   lifo_data_in         pins toward the LIFO
//   lifo_data_out,
//   lifo_val, lifo_full  status from the LIFO (data_out is top of stack)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal arbitration; flush moves to ST_FLUSH with no grant
// ST_FLUSH | gnt=0, read while lifo_val; exit to ST_RUN when empty
module lifo_port_arbiter
  import lifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int LIFO_SIZE = 8,
  parameter  int DATA_W    = 8,
  localparam int ID_W      = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_push,
  input  logic [N_REQ-1:0]        req_pop,
  input  logic [N_REQ*DATA_W-1:0] push_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic                    flush,
  output logic                    busy,
  output logic                    flush_done,
  output logic                    lifo_write,
  output logic                    lifo_read,
  output logic [DATA_W-1:0]       lifo_data_in,
  input  logic [DATA_W-1:0]       lifo_data_out,
  input  logic                    lifo_val,
  input  logic                    lifo_full
);

  // Drain bound: a LIFO of LIFO_SIZE entries cannot need more reads than
  // that, so the down-counter only matters if lifo_val misbehaves.
  localparam int DRAIN_W = $clog2(LIFO_SIZE + 1);

  arb_state_e         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               flush_done_nxt;

  logic [N_REQ-1:0]   elig_push, elig_pop, eligible;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_valid;
  lifo_op_e           gnt_op;

  // Push beats pop when a requester raises both.
  assign elig_push = req_push & {N_REQ{!lifo_full}};
  assign elig_pop  = req_pop & ~req_push & {N_REQ{lifo_val}};
  assign eligible  = (state == ST_RUN && !reset && !flush) ? (elig_push | elig_pop) : '0;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gnt_op = OP_NONE;
    if (gnt_valid) begin
      gnt_op = req_push[gnt_idx] ? OP_PUSH : OP_POP;
    end
  end

  // LIFO pin muxing; the write data is forced to zero unless pushing.
  always_comb begin
    int sel;
    sel          = int'(gnt_idx) * DATA_W;
    lifo_write   = (gnt_op == OP_PUSH);
    lifo_read    = (gnt_op == OP_POP) || (state == ST_FLUSH && !reset && lifo_val);
    lifo_data_in = '0;
    if (gnt_op == OP_PUSH) begin
      lifo_data_in = push_data[sel +: DATA_W];
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (gnt_valid) begin
      rr_ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    drain_nxt      = drain_cnt;
    flush_done_nxt = 1'b0;
    case (state)
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_FLUSH;
          drain_nxt = DRAIN_W'(LIFO_SIZE);
        end
      end
      ST_FLUSH: begin
        if (!lifo_val || drain_cnt == '0) begin
          state_nxt      = ST_RUN;
          flush_done_nxt = 1'b1;
        end else begin
          drain_nxt = drain_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      rr_ptr     <= '0;
      drain_cnt  <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      drain_cnt  <= drain_nxt;
      flush_done <= flush_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (gnt_op == OP_POP);
      if (gnt_op == OP_POP) begin
        rsp_id   <= gnt_idx;
        rsp_data <= lifo_data_out;
      end
    end
  end

  assign busy = (state == ST_FLUSH);

endmodule
